ballot_collector: RTL and testbench
===================================

Name: ballot_collector

Overview:
- Sequential front end for the combinational 4-input voter.
- Opens a voting session, collects one ballot per voter over a valid/ready handshake, and enforces a timeout window.
- Drives the assembled 4-bit vote vector into the voter, captures its 3-bit verdict, and holds the result until acknowledged.
- This is the initiator side of the voter interface: it produces I[3:0] and consumes O[3:1].

Parameters:
- N_VOTERS, 4: ballot slots; fixed to the voter input width. Only 4 is supported.
- TIMEOUT, 255: maximum number of COLLECT cycles before a forced evaluation. Must be ≥1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  opens a session; sampled only in IDLE.
- bal_valid  input  1  a ballot is offered.
- bal_ready  output  1  collector accepts ballots.
- bal_id  input  2  voter index 0..3.
- bal_vote  input  1  1 = yes, 0 = no.
- vote_vec  output  4  to voter I[3:0]; bit k = vote of voter k.
- verdict_in  input  3  from voter O[3:1].
- res_valid  output  1  result available.
- res_verdict  output  3  captured verdict.
- res_vec  output  4  captured vote vector.
- res_mask  output  4  which voters actually voted.
- res_timeout  output  1  session closed by timeout.
- res_ack  input  1  consumer accepts the result.
- dup_err  output  1  one-cycle pulse on a duplicate ballot.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs and internal registers = 0, including vote_vec, mask and timer. Any session in progress is discarded with no result.
- FSM states: IDLE -> COLLECT -> EVAL -> DONE -> IDLE.
- IDLE:
  - bal_ready=0.
  - start=1 clears vote_vec, mask and timer, then moves to COLLECT next cycle.
  - start in any other state is ignored.
- COLLECT:
  - bal_ready=1; a ballot transfers when bal_valid & bal_ready.
  - New id (mask[id]=0): set vote_vec[id]=bal_vote and mask[id]=1.
  - Duplicate id (mask[id]=1): ballot is consumed but discarded. vote_vec is unchanged. dup_err pulses in the next cycle.
  - Timer increments every COLLECT cycle.
  - Exit to EVAL when the mask becomes 4'b1111, counting the ballot accepted this cycle.
  - Otherwise exit to EVAL with res_timeout=1 when timer==TIMEOUT-1. Missing voters count as 0 (no).
  - Last ballot and timeout in the same cycle: the ballot is accepted and res_timeout=0.
- EVAL (one cycle):
  - vote_vec is stable and the voter is combinational.
  - On exit, register res_verdict<=verdict_in, res_vec<=vote_vec, res_mask<=mask; go to DONE.
- DONE:
  - res_valid=1, with res_* held stable.
  - res_ack=1 -> IDLE next cycle; res_valid and res_timeout clear.
  - The start input is not sampled here; start asserted together with res_ack is ignored.
- Latency: completing ballot accepted at edge t -> EVAL in cycle t+1 -> res_valid high after edge t+2.
- Timeout session: res_valid is seen TIMEOUT+1 cycles after COLLECT entry.
- vote_vec is driven continuously; it is only meaningful in EVAL and DONE.
- Timer width: $clog2(TIMEOUT+1). It never wraps because the exit occurs first.

Decomposition:
- Shared package ballot_pkg holds:
  - state enum {IDLE, COLLECT, EVAL, DONE};
  - N_VOTERS=4;
  - verdict bit positions VERDICT_YES=3, VERDICT_TIE=2, VERDICT_NO=1.
- One natural sub-module: ballot_timer, a loadable window counter (clear, enable, expire flag).
- The voter is instantiated by the parent, not inside ballot_collector.

Test Plan:
- Reset mid-COLLECT after 2 ballots -> busy=0, bal_ready=0, vote_vec=0, no res_valid; a new start then runs a clean session.
- start, then ballots (id,vote) = (0,1), (1,1), (2,0), (3,1) on back-to-back cycles -> vote_vec=4'b1011. res_valid exactly 2 cycles after the 4th ballot. res_vec=4'b1011, res_mask=4'b1111, res_verdict equals the voter's output for 4'b1011, res_timeout=0.
- Duplicate: (2,1), then (2,0), then ids 0, 1, 3 with vote=0 -> dup_err pulses once, vote_vec[2] stays 1, res_vec=4'b0100.
- Timeout with TIMEOUT=8 and only (1,1) sent -> res_valid at cycle 9 after COLLECT entry. res_timeout=1, res_mask=4'b0010, res_vec=4'b0010.
- Final ballot in the same cycle as timer==TIMEOUT-1 -> res_mask=4'b1111, res_timeout=0.
- Hold res_ack low for 5 cycles with start pulsed -> res_* stable and no new session. res_ack=1 -> IDLE; a later start is accepted.

Source files
------------

// File: rtl/ballot_pkg.sv
// rtl/ballot_pkg.sv - shared types and constants for the ballot collector
package ballot_pkg;

    localparam int N_VOTERS = 4;

    // Bit positions inside the voter's O[3:1] verdict bus
    localparam int VERDICT_YES = 3;
    localparam int VERDICT_TIE = 2;
    localparam int VERDICT_NO  = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [N_VOTERS-1:0] id_onehot(input logic [1:0] id);
        logic [N_VOTERS-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ballot_timer.sv
// rtl/ballot_timer.sv - clearable window counter that flags the last collect cycle
module ballot_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;

    // Count enabled cycles; saturate at LAST so the counter can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/ballot_collector.sv
// rtl/ballot_collector.sv - session FSM collecting four ballots for the combinational voter
module ballot_collector
    import ballot_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                bal_valid,
    output logic                bal_ready,
    input  logic [1:0]          bal_id,
    input  logic                bal_vote,
    output logic [N_VOTERS-1:0] vote_vec,
    input  logic [3:1]          verdict_in,
    output logic                res_valid,
    output logic [3:1]          res_verdict,
    output logic [N_VOTERS-1:0] res_vec,
    output logic [N_VOTERS-1:0] res_mask,
    output logic                res_timeout,
    input  logic                res_ack,
    output logic                dup_err,
    output logic                busy
);

    state_t              state_q;
    logic [N_VOTERS-1:0] vote_q, vote_d;
    logic [N_VOTERS-1:0] mask_q, mask_d;
    logic                bal_ready_q;
    logic                busy_q;
    logic                dup_err_q;
    logic                res_valid_q;
    logic                res_timeout_q;
    logic [3:1]          res_verdict_q;
    logic [N_VOTERS-1:0] res_vec_q;
    logic [N_VOTERS-1:0] res_mask_q;

    logic                accept;
    logic                dup;
    logic [N_VOTERS-1:0] onehot;
    logic                timer_clr;
    logic                timer_en;
    logic                expire;

    assign timer_clr = (state_q == IDLE) && start;
    assign timer_en  = (state_q == COLLECT);

    ballot_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expire_o (expire)
    );

    // Ballot acceptance: first ballot per voter is recorded, repeats are swallowed
    always_comb begin
        accept = bal_valid && bal_ready_q;
        onehot = id_onehot(bal_id);
        dup    = accept && ((mask_q & onehot) != '0);
        mask_d = mask_q;
        vote_d = vote_q;
        if (accept && !dup) begin
            mask_d = mask_q | onehot;
            vote_d = (vote_q & ~onehot) | (bal_vote ? onehot : '0);
        end
    end

    // Session FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            vote_q        <= '0;
            mask_q        <= '0;
            bal_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            dup_err_q     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            res_verdict_q <= '0;
            res_vec_q     <= '0;
            res_mask_q    <= '0;
        end else begin
            dup_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vote_q        <= '0;
                        mask_q        <= '0;
                        res_timeout_q <= 1'b0;
                        bal_ready_q   <= 1'b1;
                        busy_q        <= 1'b1;
                        state_q       <= COLLECT;
                    end
                end
                COLLECT: begin
                    vote_q    <= vote_d;
                    mask_q    <= mask_d;
                    dup_err_q <= dup;
                    // A completing ballot wins over a simultaneous timeout
                    if (mask_d == '1) begin
                        bal_ready_q <= 1'b0;
                        state_q     <= EVAL;
                    end else if (expire) begin
                        bal_ready_q   <= 1'b0;
                        res_timeout_q <= 1'b1;
                        state_q       <= EVAL;
                    end
                end
                EVAL: begin
                    res_verdict_q <= verdict_in;
                    res_vec_q     <= vote_q;
                    res_mask_q    <= mask_q;
                    res_valid_q   <= 1'b1;
                    state_q       <= DONE;
                end
                DONE: begin
                    if (res_ack) begin
                        res_valid_q   <= 1'b0;
                        res_timeout_q <= 1'b0;
                        busy_q        <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bal_ready   = bal_ready_q;
    assign busy        = busy_q;
    assign dup_err     = dup_err_q;
    assign vote_vec    = vote_q;
    assign res_valid   = res_valid_q;
    assign res_timeout = res_timeout_q;
    assign res_verdict = res_verdict_q;
    assign res_vec     = res_vec_q;
    assign res_mask    = res_mask_q;

endmodule

// File: tb/tb_ballot_collector.sv
// tb/tb_ballot_collector.sv - directed self-checking bench for ballot_collector
module tb_ballot_collector;
    import ballot_pkg::*;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bal_valid = 1'b0;
    logic       bal_ready;
    logic [1:0] bal_id = 2'd0;
    logic       bal_vote = 1'b0;
    logic [3:0] vote_vec;
    logic [3:1] verdict_in;
    logic       res_valid;
    logic [3:1] res_verdict;
    logic [3:0] res_vec;
    logic [3:0] res_mask;
    logic       res_timeout;
    logic       res_ack = 1'b0;
    logic       dup_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int dup_cnt  = 0;

    always #5 clk = ~clk;

    ballot_collector #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bal_valid   (bal_valid),
        .bal_ready   (bal_ready),
        .bal_id      (bal_id),
        .bal_vote    (bal_vote),
        .vote_vec    (vote_vec),
        .verdict_in  (verdict_in),
        .res_valid   (res_valid),
        .res_verdict (res_verdict),
        .res_vec     (res_vec),
        .res_mask    (res_mask),
        .res_timeout (res_timeout),
        .res_ack     (res_ack),
        .dup_err     (dup_err),
        .busy        (busy)
    );

    // Voter model: majority yes / tie / majority no
    int yes_cnt;
    always_comb begin
        yes_cnt = 0;
        for (int k = 0; k < 4; k++) yes_cnt += int'(vote_vec[k]);
        verdict_in = '0;
        if (yes_cnt > 2)       verdict_in[VERDICT_YES] = 1'b1;
        else if (yes_cnt == 2) verdict_in[VERDICT_TIE] = 1'b1;
        else                   verdict_in[VERDICT_NO]  = 1'b1;
    end

    always @(negedge clk) if (dup_err) dup_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_session();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] id, input logic v);
        bal_valid = 1'b1;
        bal_id    = id;
        bal_vote  = v;
        @(negedge clk);
        bal_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!res_valid) check({tag, "_res_valid_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic ack();
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    int cyc;
    int d0;

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bal_ready), 32'd0);
        check("rst_vec", 32'(vote_vec), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-COLLECT after two ballots
        start_session();
        check("collect_ready", 32'(bal_ready), 32'd1);
        send(2'd0, 1'b1);
        send(2'd1, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(bal_ready), 32'd0);
        check("midrst_vec", 32'(vote_vec), 32'd0);
        check("midrst_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_session();
        for (int i = 0; i < 4; i++) send(2'(i), 1'b1);
        wait_result("clean", cyc);
        check("clean_vec", 32'(res_vec), 32'hF);
        check("clean_verdict", 32'(res_verdict), 32'b100);
        ack();

        // Back-to-back ballots, result exactly two cycles after the 4th
        start_session();
        send(2'd0, 1'b1);
        send(2'd1, 1'b1);
        send(2'd2, 1'b0);
        send(2'd3, 1'b1);
        check("b2b_eval_valid", 32'(res_valid), 32'd0);
        check("b2b_vote_vec", 32'(vote_vec), 32'hB);
        check("b2b_eval_ready", 32'(bal_ready), 32'd0);
        @(negedge clk);
        check("b2b_valid", 32'(res_valid), 32'd1);
        check("b2b_vec", 32'(res_vec), 32'hB);
        check("b2b_mask", 32'(res_mask), 32'hF);
        check("b2b_verdict", 32'(res_verdict), 32'b100);
        check("b2b_timeout", 32'(res_timeout), 32'd0);
        ack();
        check("b2b_ack_valid", 32'(res_valid), 32'd0);
        check("b2b_ack_busy", 32'(busy), 32'd0);

        // Duplicate ballot is dropped and flagged once
        d0 = dup_cnt;
        start_session();
        send(2'd2, 1'b1);
        send(2'd2, 1'b0);
        check("dup_pulse", 32'(dup_err), 32'd1);
        send(2'd0, 1'b0);
        check("dup_pulse_clear", 32'(dup_err), 32'd0);
        check("dup_vec2", 32'(vote_vec[2]), 32'd1);
        send(2'd1, 1'b0);
        send(2'd3, 1'b0);
        wait_result("dup", cyc);
        check("dup_count", 32'(dup_cnt - d0), 32'd1);
        check("dup_vec", 32'(res_vec), 32'h4);
        check("dup_mask", 32'(res_mask), 32'hF);
        check("dup_verdict", 32'(res_verdict), 32'b001);
        ack();

        // Timeout with a single ballot: result TIMEOUT+1 cycles after entry
        start_session();
        cyc = 0;
        send(2'd1, 1'b1);
        cyc = 1;
        while (!res_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("to_latency", 32'(cyc), 32'(TO + 1));
        check("to_flag", 32'(res_timeout), 32'd1);
        check("to_mask", 32'(res_mask), 32'h2);
        check("to_vec", 32'(res_vec), 32'h2);
        check("to_verdict", 32'(res_verdict), 32'b001);
        ack();
        check("to_flag_clear", 32'(res_timeout), 32'd0);

        // Final ballot lands in the last window cycle: completion beats timeout
        start_session();
        send(2'd0, 1'b1);
        send(2'd1, 1'b0);
        send(2'd2, 1'b1);
        for (int i = 3; i < TO - 1; i++) @(negedge clk);
        check("edge_still_collect", 32'(bal_ready), 32'd1);
        send(2'd3, 1'b0);
        @(negedge clk);
        check("edge_valid", 32'(res_valid), 32'd1);
        check("edge_mask", 32'(res_mask), 32'hF);
        check("edge_timeout", 32'(res_timeout), 32'd0);
        check("edge_vec", 32'(res_vec), 32'h5);
        check("edge_verdict", 32'(res_verdict), 32'b010);

        // Hold DONE without ack; start must be ignored
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_vec", 32'(res_vec), 32'h5);
            check("hold_mask", 32'(res_mask), 32'hF);
            check("hold_ready", 32'(bal_ready), 32'd0);
        end
        start   = 1'b1;
        res_ack = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        res_ack = 1'b0;
        check("ackstart_busy", 32'(busy), 32'd0);
        check("ackstart_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("ackstart_idle", 32'(bal_ready), 32'd0);
        start_session();
        check("restart_ready", 32'(bal_ready), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
